// File: rtl/clock_time_keeper.sv
// ============================================================================
// Module   : clock_time_keeper
// Brief    : BCD time-of-day counter driven by a divided tick clock, with
//            synchronous validated load and run/hold control.
//            Optional 12-hour mode with PM flag: define CLOCK_12H_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clock_time_keeper #(
    parameter int TICKS_PER_SEC = 1000,
    parameter int CNT_W         = 10
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Tick_In,
    input  logic       Run,
    input  logic       Load,
    input  logic [7:0] Load_Hour,
    input  logic [7:0] Load_Min,
    input  logic [7:0] Load_Sec,
`ifdef CLOCK_12H_EN
    input  logic       Load_PM,
    output logic       PM,
`endif
    output logic [7:0] Hour,
    output logic [7:0] Min,
    output logic [7:0] Sec,
    output logic       Sec_Pulse,
    output logic       Load_Err
);

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TICKS_PER_SEC - 1);
`ifdef CLOCK_12H_EN
    localparam logic [7:0] c_HOUR_RST = 8'h12;
`else
    localparam logic [7:0] c_HOUR_RST = 8'h00;
`endif

    logic             r_s1, r_s2, r_s3;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_hour, r_min, r_sec;
    logic             r_sec_pulse, r_load_err;
`ifdef CLOCK_12H_EN
    logic             r_pm;
    logic             w_pm_next;
`endif

    logic       w_tick, w_step, w_cnt_last, w_sec_carry;
    logic       w_min_carry, w_hour_carry, w_load_ok;
    logic [7:0] w_sec_next, w_min_next, w_hour_next;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Both digits must be decimal; BCD then orders like plain binary.
    function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] lim);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v < lim);
    endfunction

    always_comb begin
        w_tick       = r_s2 & ~r_s3;
        w_step       = w_tick & Run & ~Load;
        w_cnt_last   = (r_cnt == c_CNT_LAST);
        w_sec_carry  = w_step & w_cnt_last;
        w_min_carry  = (r_sec == 8'h59);
        w_hour_carry = w_min_carry & (r_min == 8'h59);
        w_sec_next   = w_min_carry ? 8'h00 : bcd_inc(r_sec);
        w_min_next   = (r_min == 8'h59) ? 8'h00 : bcd_inc(r_min);
`ifdef CLOCK_12H_EN
        w_hour_next  = (r_hour == 8'h12) ? 8'h01 : bcd_inc(r_hour);
        w_pm_next    = r_pm ^ (r_hour == 8'h11);
        w_load_ok    = bcd_ok(Load_Sec, 8'h60) && bcd_ok(Load_Min, 8'h60) &&
                       bcd_ok(Load_Hour, 8'h13) && (Load_Hour != 8'h00);
`else
        w_hour_next  = (r_hour == 8'h23) ? 8'h00 : bcd_inc(r_hour);
        w_load_ok    = bcd_ok(Load_Sec, 8'h60) && bcd_ok(Load_Min, 8'h60) &&
                       bcd_ok(Load_Hour, 8'h24);
`endif
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_s1        <= 1'b0;
            r_s2        <= 1'b0;
            r_s3        <= 1'b0;
            r_cnt       <= '0;
            r_hour      <= c_HOUR_RST;
            r_min       <= 8'h00;
            r_sec       <= 8'h00;
            r_sec_pulse <= 1'b0;
            r_load_err  <= 1'b0;
`ifdef CLOCK_12H_EN
            r_pm        <= 1'b0;
`endif
        end else begin
            // Synchronizer runs regardless of Run so no stale edge is seen later.
            r_s1        <= Tick_In;
            r_s2        <= r_s1;
            r_s3        <= r_s2;
            r_sec_pulse <= w_sec_carry;
            r_load_err  <= Load & ~w_load_ok;
            if (Load) begin
                if (w_load_ok) begin
                    r_hour <= Load_Hour;
                    r_min  <= Load_Min;
                    r_sec  <= Load_Sec;
                    r_cnt  <= '0;
`ifdef CLOCK_12H_EN
                    r_pm   <= Load_PM;
`endif
                end
            end else if (w_sec_carry) begin
                r_cnt <= '0;
                r_sec <= w_sec_next;
                if (w_min_carry)
                    r_min <= w_min_next;
                if (w_hour_carry) begin
                    r_hour <= w_hour_next;
`ifdef CLOCK_12H_EN
                    r_pm   <= w_pm_next;
`endif
                end
            end else if (w_step) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign Hour      = r_hour;
    assign Min       = r_min;
    assign Sec       = r_sec;
    assign Sec_Pulse = r_sec_pulse;
    assign Load_Err  = r_load_err;
`ifdef CLOCK_12H_EN
    assign PM        = r_pm;
`endif

endmodule

`default_nettype wire
